bp_update_scheduler: RTL and testbench
======================================

Name: bp_update_scheduler

Overview:
- Sequences all writes into the branch predictor tables (tag, target and BHT) through one shared write port.
- On reset it runs a table-clear sweep, one entry per cycle.
- In normal operation it arbitrates two requesters: EX-stage branch resolution (BHT update, highest priority, never stalled) and ID-stage target install (tag+target, flow-controlled, queued in a small FIFO).
- Sits between the ID/EX pipeline control and the predictor storage.

Parameters:
WORD_SIZE, 16, PC/target width
IDX_SIZE, 8, table index width; tag width = WORD_SIZE-IDX_SIZE; table has 2**IDX_SIZE entries
FIFO_DEPTH, 4, pending ID-install entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
init_busy  out  1  1 while clear sweep in progress; pipeline must stall
id_req_valid  in  1  ID install request
id_req_ready  out  1  ID request accepted when valid&ready at posedge
id_req_pc  in  WORD_SIZE  PC of jump/branch at ID
id_req_target  in  WORD_SIZE  computed target
ex_req_valid  in  1  EX resolution event; no ready, must never be dropped in RUN
ex_req_pc  in  WORD_SIZE  PC of resolved branch
ex_req_correct  in  1  1 = prediction was correct
wr_en  out  1  table write strobe
wr_op  out  2  0=CLEAR, 1=INSTALL, 2=BHT, 3 unused
wr_idx  out  IDX_SIZE  table index = pc[IDX_SIZE-1:0]
wr_tag  out  WORD_SIZE-IDX_SIZE  pc[WORD_SIZE-1:IDX_SIZE]; 0 for CLEAR
wr_target  out  WORD_SIZE  target for INSTALL; 0 otherwise
wr_correct  out  1  ex_req_correct for BHT; 0 otherwise

Behaviour:
- All wr_* outputs and init_busy are registered.
- Reset (reset_n=0 at posedge):
  - state=INIT, sweep counter=0, FIFO empty.
  - wr_en=0, wr_op=0, wr_idx=0, wr_tag=0, wr_target=0, wr_correct=0.
  - init_busy=1, id_req_ready=0.
- INIT state:
  - Each posedge issues wr_en=1, wr_op=CLEAR, wr_idx=counter, then counter+1.
  - The edge that issues idx 2**IDX_SIZE-1 also moves the state to RUN and clears init_busy.
  - Exactly 2**IDX_SIZE consecutive CLEAR writes, indices ascending from 0.
  - id_req_ready=0 throughout. ex_req_valid is ignored (pipeline is stalled).
- RUN state, evaluated per posedge:
  - If ex_req_valid=1: issue BHT (wr_idx/wr_tag from ex_req_pc, wr_correct=ex_req_correct).
  - Else if FIFO non-empty: pop head and issue INSTALL.
  - Else if an ID request is accepted this edge: issue it directly as INSTALL (bypass, no FIFO entry).
  - Else wr_en=0; the other wr_* fields hold their last values.
  - An accepted ID request not issued this edge is pushed to the FIFO tail. Push and pop may occur on the same edge.
  - Latency: accept to wr_en is 1 cycle with no contention; +1 cycle per EX event and per older queued entry.
  - Install order equals acceptance order.
- id_req_ready = (state==RUN) && (FIFO count < FIFO_DEPTH). It is combinational from registered state and deliberately ignores a same-cycle pop.
- Sustained EX traffic may starve ID. The FIFO fills, ready drops and ID stalls; this is intended.
- Reset asserted mid-operation discards queued installs and restarts the full sweep from idx 0.
- No dedup: repeated installs to the same idx are all issued; the later write wins.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, add output ports stat_correct (16) and stat_mispredict (16). These count issued BHT writes with wr_correct=1 and 0 respectively.
  - Both increment on the same edge as the write is issued.
  - Both saturate at 16'hFFFF.
  - Both clear to 0 on reset.
- When undefined, the ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Release reset with IDX_SIZE=8 -> 256 consecutive CLEAR writes, idx 0..255. init_busy falls on the edge issuing idx 255. id_req_ready=0 until then.
- RUN, idle. One ID request pc=16'h1234, target=16'h2000 -> next cycle wr_op=INSTALL, wr_idx=8'h34, wr_tag=8'h12, wr_target=16'h2000, FIFO stays empty.
- Same-cycle ex_req (pc=16'h0105, correct=0) and ID request (pc=16'h0207) -> cycle 1 BHT idx 8'h05 correct=0; cycle 2 INSTALL idx 8'h07.
- Hold ex_req_valid=1 for 6 cycles while ID offers 5 requests -> first 4 accepted, then id_req_ready=0. After EX stops, 4 INSTALLs issue in acceptance order, then the 5th is accepted.
- Assert reset_n=0 for one cycle while 3 installs are queued -> no queued INSTALL ever appears. A fresh 256-CLEAR sweep starts from idx 0.
- BP_STATS_EN defined: 3 correct and 2 incorrect EX events -> stat_correct=3, stat_mispredict=2. Preload near saturation via 65540 correct events -> stat_correct holds 16'hFFFF.

Source files
------------

// File: rtl/bp_update_scheduler_if.sv
// Request/write bundle for bp_update_scheduler.
// slave : the scheduler itself (accepts ID/EX requests, drives the table write port)
// master: the pipeline control / predictor storage side
interface bp_update_scheduler_if #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_SIZE  = 8
);
    // ID-stage target install request (flow-controlled)
    logic                          id_req_valid;
    logic                          id_req_ready;
    logic [WORD_SIZE-1:0]          id_req_pc;
    logic [WORD_SIZE-1:0]          id_req_target;

    // EX-stage branch resolution (never stalled)
    logic                          ex_req_valid;
    logic [WORD_SIZE-1:0]          ex_req_pc;
    logic                          ex_req_correct;

    // Shared predictor table write port
    logic                          wr_en;
    logic [1:0]                    wr_op;
    logic [IDX_SIZE-1:0]           wr_idx;
    logic [WORD_SIZE-IDX_SIZE-1:0] wr_tag;
    logic [WORD_SIZE-1:0]          wr_target;
    logic                          wr_correct;

    modport slave (
        input  id_req_valid, id_req_pc, id_req_target,
        input  ex_req_valid, ex_req_pc, ex_req_correct,
        output id_req_ready,
        output wr_en, wr_op, wr_idx, wr_tag, wr_target, wr_correct
    );

    modport master (
        output id_req_valid, id_req_pc, id_req_target,
        output ex_req_valid, ex_req_pc, ex_req_correct,
        input  id_req_ready,
        input  wr_en, wr_op, wr_idx, wr_tag, wr_target, wr_correct
    );
endinterface

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: serialises all branch-predictor table writes through
// one write port. After reset it clears every table entry (one per cycle),
// then arbitrates EX-stage BHT updates (highest priority, never stalled)
// against ID-stage target installs (queued in a small FIFO).
// Optional build macro: BP_STATS_EN adds saturating BHT correct/mispredict
// counters on ports stat_correct / stat_mispredict.
module bp_update_scheduler #(
    parameter int WORD_SIZE  = 16,
    parameter int IDX_SIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   init_busy,
    bp_update_scheduler_if.slave   bus
`ifdef BP_STATS_EN
    ,
    output logic [15:0]            stat_correct,
    output logic [15:0]            stat_mispredict
`endif
);

    localparam int TAG_W = WORD_SIZE - IDX_SIZE;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] OP_CLEAR   = 2'd0;
    localparam logic [1:0] OP_INSTALL = 2'd1;
    localparam logic [1:0] OP_BHT     = 2'd2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Table index part of a PC
    function automatic logic [IDX_SIZE-1:0] idx_of(input logic [WORD_SIZE-1:0] pc);
        return pc[IDX_SIZE-1:0];
    endfunction

    // Tag part of a PC
    function automatic logic [TAG_W-1:0] tag_of(input logic [WORD_SIZE-1:0] pc);
        return pc[WORD_SIZE-1:IDX_SIZE];
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_SIZE-1:0]    sweep_cnt_r;
    logic                   sweep_last_s;

    logic [WORD_SIZE-1:0]   fifo_pc_r     [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]   fifo_target_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [WORD_SIZE-1:0]   head_pc_s;
    logic [WORD_SIZE-1:0]   head_target_s;

    logic                   id_ready_s;
    logic                   accept_s;
    logic                   issue_bht_s;
    logic                   pop_s;
    logic                   bypass_s;
    logic                   push_s;

    logic                   wr_en_nxt_s;
    logic [1:0]             wr_op_nxt_s;
    logic [IDX_SIZE-1:0]    wr_idx_nxt_s;
    logic [TAG_W-1:0]       wr_tag_nxt_s;
    logic [WORD_SIZE-1:0]   wr_target_nxt_s;
    logic                   wr_correct_nxt_s;

    logic                   wr_en_r;
    logic [1:0]             wr_op_r;
    logic [IDX_SIZE-1:0]    wr_idx_r;
    logic [TAG_W-1:0]       wr_tag_r;
    logic [WORD_SIZE-1:0]   wr_target_r;
    logic                   wr_correct_r;
    logic                   init_busy_r;

    assign sweep_last_s  = (sweep_cnt_r == {IDX_SIZE{1'b1}});
    assign head_pc_s     = fifo_pc_r[rd_ptr_r];
    assign head_target_s = fifo_target_r[rd_ptr_r];

    // Arbitration: EX first, then oldest queued install, then same-cycle bypass
    always_comb begin
        id_ready_s  = (state_r == ST_RUN) && (count_r < DEPTH_C);
        accept_s    = bus.id_req_valid && id_ready_s;
        issue_bht_s = 1'b0;
        pop_s       = 1'b0;
        bypass_s    = 1'b0;
        if (state_r == ST_RUN) begin
            if (bus.ex_req_valid) begin
                issue_bht_s = 1'b1;
            end else if (count_r != {CNT_W{1'b0}}) begin
                pop_s = 1'b1;
            end else if (accept_s) begin
                bypass_s = 1'b1;
            end else begin
                bypass_s = 1'b0;
            end
        end else begin
            issue_bht_s = 1'b0;
        end
        push_s = accept_s && !bypass_s;
    end

    assign bus.id_req_ready = id_ready_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave INIT on the edge that clears the last entry
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_last_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // FSM outputs: next values of the write port (fields hold when idle)
    always_comb begin
        wr_en_nxt_s      = 1'b0;
        wr_op_nxt_s      = wr_op_r;
        wr_idx_nxt_s     = wr_idx_r;
        wr_tag_nxt_s     = wr_tag_r;
        wr_target_nxt_s  = wr_target_r;
        wr_correct_nxt_s = wr_correct_r;
        case (state_r)
            ST_INIT: begin
                wr_en_nxt_s      = 1'b1;
                wr_op_nxt_s      = OP_CLEAR;
                wr_idx_nxt_s     = sweep_cnt_r;
                wr_tag_nxt_s     = {TAG_W{1'b0}};
                wr_target_nxt_s  = {WORD_SIZE{1'b0}};
                wr_correct_nxt_s = 1'b0;
            end
            ST_RUN: begin
                if (issue_bht_s) begin
                    wr_en_nxt_s      = 1'b1;
                    wr_op_nxt_s      = OP_BHT;
                    wr_idx_nxt_s     = idx_of(bus.ex_req_pc);
                    wr_tag_nxt_s     = tag_of(bus.ex_req_pc);
                    wr_target_nxt_s  = {WORD_SIZE{1'b0}};
                    wr_correct_nxt_s = bus.ex_req_correct;
                end else if (pop_s) begin
                    wr_en_nxt_s      = 1'b1;
                    wr_op_nxt_s      = OP_INSTALL;
                    wr_idx_nxt_s     = idx_of(head_pc_s);
                    wr_tag_nxt_s     = tag_of(head_pc_s);
                    wr_target_nxt_s  = head_target_s;
                    wr_correct_nxt_s = 1'b0;
                end else if (bypass_s) begin
                    wr_en_nxt_s      = 1'b1;
                    wr_op_nxt_s      = OP_INSTALL;
                    wr_idx_nxt_s     = idx_of(bus.id_req_pc);
                    wr_tag_nxt_s     = tag_of(bus.id_req_pc);
                    wr_target_nxt_s  = bus.id_req_target;
                    wr_correct_nxt_s = 1'b0;
                end else begin
                    wr_en_nxt_s = 1'b0;
                end
            end
            default: begin
                wr_en_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered write port and init_busy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en_r      <= 1'b0;
            wr_op_r      <= OP_CLEAR;
            wr_idx_r     <= {IDX_SIZE{1'b0}};
            wr_tag_r     <= {TAG_W{1'b0}};
            wr_target_r  <= {WORD_SIZE{1'b0}};
            wr_correct_r <= 1'b0;
            init_busy_r  <= 1'b1;
        end else begin
            wr_en_r      <= wr_en_nxt_s;
            wr_op_r      <= wr_op_nxt_s;
            wr_idx_r     <= wr_idx_nxt_s;
            wr_tag_r     <= wr_tag_nxt_s;
            wr_target_r  <= wr_target_nxt_s;
            wr_correct_r <= wr_correct_nxt_s;
            init_busy_r  <= (state_nxt_s == ST_INIT);
        end
    end

    assign bus.wr_en      = wr_en_r;
    assign bus.wr_op      = wr_op_r;
    assign bus.wr_idx     = wr_idx_r;
    assign bus.wr_tag     = wr_tag_r;
    assign bus.wr_target  = wr_target_r;
    assign bus.wr_correct = wr_correct_r;
    assign init_busy      = init_busy_r;

    // Clear-sweep index counter, advances only while sweeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sweep_cnt_r <= {IDX_SIZE{1'b0}};
        end else if (state_r == ST_INIT) begin
            sweep_cnt_r <= sweep_cnt_r + {{(IDX_SIZE-1){1'b0}}, 1'b1};
        end else begin
            sweep_cnt_r <= sweep_cnt_r;
        end
    end

    // FIFO pointers and occupancy; reset drops any queued installs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage, written at the tail on push
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]     <= bus.id_req_pc;
            fifo_target_r[wr_ptr_r] <= bus.id_req_target;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] stat_correct_r;
    logic [15:0] stat_mispredict_r;

    // Saturating BHT outcome counters, bumped on the edge the write issues
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_correct_r    <= 16'h0000;
            stat_mispredict_r <= 16'h0000;
        end else if (issue_bht_s) begin
            if (bus.ex_req_correct) begin
                if (stat_correct_r != 16'hFFFF) begin
                    stat_correct_r <= stat_correct_r + 16'h0001;
                end
            end else begin
                if (stat_mispredict_r != 16'hFFFF) begin
                    stat_mispredict_r <= stat_mispredict_r + 16'h0001;
                end
            end
        end
    end

    assign stat_correct    = stat_correct_r;
    assign stat_mispredict = stat_mispredict_r;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler (WORD_SIZE=16,
// IDX_SIZE=8, FIFO_DEPTH=4). Inputs change 1ns after posedge; outputs are
// sampled at the same point, well away from the next active edge.
module tb_bp_update_scheduler;

    logic        clk;
    logic        reset_n;
    logic        init_busy;
`ifdef BP_STATS_EN
    logic [15:0] stat_correct;
    logic [15:0] stat_mispredict;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    bp_update_scheduler_if #(.WORD_SIZE(16), .IDX_SIZE(8)) bif ();

    bp_update_scheduler #(
        .WORD_SIZE (16),
        .IDX_SIZE  (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .init_busy      (init_busy),
        .bus            (bif)
`ifdef BP_STATS_EN
        ,
        .stat_correct   (stat_correct),
        .stat_mispredict(stat_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] op, input logic [7:0] idx,
                          input logic [7:0] tg, input logic [15:0] tgt, input logic cor);
        chk({tag, "_en"},      {31'd0, bif.wr_en},      32'd1);
        chk({tag, "_op"},      {30'd0, bif.wr_op},      {30'd0, op});
        chk({tag, "_idx"},     {24'd0, bif.wr_idx},     {24'd0, idx});
        chk({tag, "_tag"},     {24'd0, bif.wr_tag},     {24'd0, tg});
        chk({tag, "_target"},  {16'd0, bif.wr_target},  {16'd0, tgt});
        chk({tag, "_correct"}, {31'd0, bif.wr_correct}, {31'd0, cor});
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 256; i++) begin
            tick();
            chk({tag, "_en"},    {31'd0, bif.wr_en},     32'd1);
            chk({tag, "_op"},    {30'd0, bif.wr_op},     32'd0);
            chk({tag, "_idx"},   {24'd0, bif.wr_idx},    i);
            chk({tag, "_busy"},  {31'd0, init_busy},     (i == 255) ? 32'd0 : 32'd1);
            chk({tag, "_ready"}, {31'd0, bif.id_req_ready}, (i == 255) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int j;
        reset_n            = 1'b0;
        bif.id_req_valid   = 1'b0;
        bif.id_req_pc      = 16'h0000;
        bif.id_req_target  = 16'h0000;
        bif.ex_req_valid   = 1'b0;
        bif.ex_req_pc      = 16'h0000;
        bif.ex_req_correct = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_wr_en",  {31'd0, bif.wr_en},        32'd0);
        chk("rst_wr_op",  {30'd0, bif.wr_op},        32'd0);
        chk("rst_wr_idx", {24'd0, bif.wr_idx},       32'd0);
        chk("rst_target", {16'd0, bif.wr_target},    32'd0);
        chk("rst_busy",   {31'd0, init_busy},        32'd1);
        chk("rst_ready",  {31'd0, bif.id_req_ready}, 32'd0);

        // Clear sweep; EX traffic during INIT must be ignored
        reset_n          = 1'b1;
        bif.ex_req_valid = 1'b1;
        bif.ex_req_pc    = 16'h0F0F;
        sweep("init");
        bif.ex_req_valid = 1'b0;

        // Single ID install with an idle scheduler: bypass path
        bif.id_req_valid  = 1'b1;
        bif.id_req_pc     = 16'h1234;
        bif.id_req_target = 16'h2000;
        tick();
        bif.id_req_valid  = 1'b0;
        chk_wr("byp", 2'd1, 8'h34, 8'h12, 16'h2000, 1'b0);
        tick();
        chk("byp_idle_en",  {31'd0, bif.wr_en},        32'd0);
        chk("byp_hold_op",  {30'd0, bif.wr_op},        32'd1);
        chk("byp_hold_idx", {24'd0, bif.wr_idx},       32'h34);
        chk("byp_ready",    {31'd0, bif.id_req_ready}, 32'd1);

        // Same-cycle EX and ID: BHT first, INSTALL next
        bif.ex_req_valid   = 1'b1;
        bif.ex_req_pc      = 16'h0105;
        bif.ex_req_correct = 1'b0;
        bif.id_req_valid   = 1'b1;
        bif.id_req_pc      = 16'h0207;
        bif.id_req_target  = 16'h0300;
        tick();
        bif.ex_req_valid   = 1'b0;
        bif.id_req_valid   = 1'b0;
        chk_wr("mix_bht", 2'd2, 8'h05, 8'h01, 16'h0000, 1'b0);
        tick();
        chk_wr("mix_ins", 2'd1, 8'h07, 8'h02, 16'h0300, 1'b0);
        tick();
        chk("mix_idle_en", {31'd0, bif.wr_en}, 32'd0);

        // Six EX cycles starve ID: four accepted, then ready drops
        j = 0;
        bif.ex_req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bif.ex_req_pc      = 16'h0500 + 16'(c);
            bif.ex_req_correct = c[0];
            bif.id_req_valid   = 1'b1;
            bif.id_req_pc      = 16'h0A10 + 16'(j);
            bif.id_req_target  = 16'h1000 + 16'(j);
            chk("stv_ready", {31'd0, bif.id_req_ready}, (c < 4) ? 32'd1 : 32'd0);
            tick();
            if (c < 4) j++;
            chk_wr("stv_bht", 2'd2, 8'(c), 8'h05, 16'h0000, c[0]);
        end
        bif.ex_req_valid = 1'b0;
        chk("stv_full_ready", {31'd0, bif.id_req_ready}, 32'd0);
        tick();
        chk_wr("stv_ins0", 2'd1, 8'h10, 8'h0A, 16'h1000, 1'b0);
        chk("stv_reopen", {31'd0, bif.id_req_ready}, 32'd1);
        tick();
        bif.id_req_valid = 1'b0;
        chk_wr("stv_ins1", 2'd1, 8'h11, 8'h0A, 16'h1001, 1'b0);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk_wr("stv_insn", 2'd1, 8'h10 + 8'(k), 8'h0A, 16'h1000 + 16'(k), 1'b0);
        end
        tick();
        chk("stv_drained_en", {31'd0, bif.wr_en}, 32'd0);

        // Reset with three installs queued behind EX traffic
        bif.ex_req_valid   = 1'b1;
        bif.ex_req_correct = 1'b1;
        bif.ex_req_pc      = 16'h0600;
        for (int k = 0; k < 3; k++) begin
            bif.id_req_valid  = 1'b1;
            bif.id_req_pc     = 16'h0B20 + 16'(k);
            bif.id_req_target = 16'h3000 + 16'(k);
            tick();
            chk("rq_bht_op", {30'd0, bif.wr_op}, 32'd2);
        end
        bif.ex_req_valid = 1'b0;
        bif.id_req_valid = 1'b0;
        reset_n          = 1'b0;
        tick();
        chk("rq_rst_en",    {31'd0, bif.wr_en},        32'd0);
        chk("rq_rst_idx",   {24'd0, bif.wr_idx},       32'd0);
        chk("rq_rst_busy",  {31'd0, init_busy},        32'd1);
        chk("rq_rst_ready", {31'd0, bif.id_req_ready}, 32'd0);
        reset_n = 1'b1;
        sweep("resweep");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rq_no_install", {31'd0, bif.wr_en}, 32'd0);
        end

`ifdef BP_STATS_EN
        // BHT outcome counters
        chk("st_zero_c", {16'd0, stat_correct},    32'd0);
        chk("st_zero_m", {16'd0, stat_mispredict}, 32'd0);
        bif.ex_req_valid = 1'b1;
        bif.ex_req_pc    = 16'h0700;
        for (int k = 0; k < 5; k++) begin
            bif.ex_req_correct = (k < 3) ? 1'b1 : 1'b0;
            tick();
        end
        bif.ex_req_valid = 1'b0;
        chk("st_c3", {16'd0, stat_correct},    32'd3);
        chk("st_m2", {16'd0, stat_mispredict}, 32'd2);
        bif.ex_req_valid   = 1'b1;
        bif.ex_req_correct = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            tick();
        end
        bif.ex_req_valid = 1'b0;
        tick();
        chk("st_sat_c", {16'd0, stat_correct},    32'h0000FFFF);
        chk("st_sat_m", {16'd0, stat_mispredict}, 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
